// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Fixed-latency data-memory responder for a pipeline memory stage. A single
// load or store is accepted while the block is idle. The block waits LATENCY
// cycles and then produces a one-cycle response strobe carrying load data or
// an error flag. Only one request is in flight at a time, so the pipeline is
// stalled (busy=1) for the whole transaction.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words of backing storage (default 1024)
//   LATENCY     : wait cycles between accept and response, legal 0..15
//
// Ports
//   clk        in   single clock, all state updates on the rising edge
//   reset      in   asynchronous reset, active low (0 = reset asserted)
//   req_valid  in   memory stage presents a request
//   req_ready  out  responder can accept a request this cycle (idle only)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address (must be word aligned, within storage)
//   req_wdata  in   store data
//   req_be     in   store byte enables, bit i covers wdata[8i+7:8i]
//   resp_valid out  one-cycle response strobe
//   resp_rdata out  load data while resp_valid=1, otherwise 0
//   resp_err   out  misaligned / out-of-range request while resp_valid=1
//   busy       out  stall to the pipeline, 1 whenever not idle
//
// Timing (cycle in which the request is accepted = cycle 0)
//   cycle 1 .. LATENCY : WAIT, counter counts down from LATENCY to 1
//   cycle LATENCY+1    : RESP, resp_valid=1
//   cycle LATENCY+2    : IDLE again, next request may be accepted
// The memory side effect (store commit or load sample) happens on the clock
// edge that enters RESP, so a transaction aborted by reset commits nothing.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  // Width of the word index into storage; at least one bit.
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q,      state_d;
  logic [3:0]  cnt_q,        cnt_d;
  logic        lat_we_q,     lat_we_d;
  logic [31:0] lat_addr_q,   lat_addr_d;
  logic [31:0] lat_wdata_q,  lat_wdata_d;
  logic [3:0]  lat_be_q,     lat_be_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q,   resp_err_d;

  // Backing storage
  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             in_idle;
  logic             accept;
  logic             enter_resp;
  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic             cur_misaligned;
  logic             cur_out_of_range;
  logic             cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      rd_word;
  logic             mem_we;

  // Ready is held low while reset is asserted, then follows the idle state.
  assign in_idle   = (state_q == S_IDLE);
  assign req_ready = reset && in_idle;
  assign accept    = req_valid && req_ready;

  // "Current" request: with LATENCY=0 the edge that accepts a request is also
  // the edge that enters RESP, so the latched copy does not exist yet and the
  // live inputs must be used. In every other case the latched copy is used,
  // which is also what makes req_* changes outside IDLE harmless.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    cur_we    = lat_we_q;
    cur_addr  = lat_addr_q;
    cur_wdata = lat_wdata_q;
    cur_be    = lat_be_q;
    if (in_idle) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
  end

  // Error decode on the current request: misaligned byte address, or a word
  // index beyond the end of storage. The range check uses the full 30-bit
  // word address so high address bits cannot alias into storage.
  always_comb begin
    cur_misaligned   = (cur_addr[1:0] != 2'b00);
    cur_out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    cur_err          = cur_misaligned || cur_out_of_range;
    cur_idx          = cur_addr[IDX_W+1:2];
  end

  // Asynchronous read of the addressed word; only consumed for in-range loads.
  assign rd_word = mem[cur_idx];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lat_we_d    = req_we;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          lat_be_d    = req_be;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(LATENCY);
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Counter reaches 0 on the same edge that enters RESP. The <= 1 test
        // also rescues the FSM if it ever sits in WAIT with a zero count.
        cnt_d = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        // Single response cycle, no accept here.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // The memory side effect and the registered response are both keyed off
  // the edge that moves the FSM into RESP.
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // Store commit: non-error store with at least one enabled byte.
  assign mem_we = enter_resp && cur_we && !cur_err && (cur_be != 4'b0000);

  // Response registers: zero unless the RESP cycle is being entered, which
  // keeps rdata/err at 0 whenever resp_valid is 0.
  always_comb begin
    resp_valid_d = enter_resp;
    resp_err_d   = enter_resp && cur_err;
    resp_rdata_d = 32'h0;
    if (enter_resp && !cur_err && !cur_we) begin
      resp_rdata_d = rd_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: flops are written with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= 32'h0;
      lat_wdata_q  <= 32'h0;
      lat_be_q     <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_be_q     <= lat_be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // NOTE: storage has no reset. Its contents must survive a reset pulse, and
  // a reset on a RAM array would also prevent it mapping onto RAM macros.
  // Writes are byte-masked; an aborted transaction never reaches this edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) begin
          mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Two instances: LATENCY=2 (main checks) and LATENCY=0. Stimulus tasks push
// the hand-computed expected response (data, error flag, cycle it must
// appear) into a per-instance queue; a monitor per instance pops and compares
// whenever resp_valid is seen, and checks rdata/err are zero otherwise.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk;
  logic reset;

  // LATENCY=2 instance (a_*) and LATENCY=0 instance (b_*)
  logic        a_valid, a_ready, a_we, a_resp_valid, a_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        b_valid, b_ready, b_we, b_resp_valid, b_err, b_busy;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;

  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t qa[$];
  exp_t qb[$];

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .resp_valid(a_resp_valid), .resp_rdata(a_rdata), .resp_err(a_err),
    .busy(a_busy)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .resp_valid(b_resp_valid), .resp_rdata(b_rdata), .resp_err(b_err),
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    if (sel) begin
      b_valid = v; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
    end else begin
      a_valid = v; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
    end
  endtask

  // Issue one request, push its expected response, then scramble the inputs
  // while the transaction is in flight (they must be ignored).
  task automatic issue(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    drive(sel, 1'b1, we, addr, wdata, be);
    while (!(sel ? b_ready : a_ready) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready stayed 0 for 50 cycles, required 1");
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      return;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.due   = cyc + 1 + (sel ? 0 : 2);
    if (sel) qb.push_back(e); else qa.push_back(e);
    @(negedge clk);
    drive(sel, 1'b0, ~we, addr ^ 32'h0000_0FF0, ~wdata, ~be);
  endtask

  task automatic wait_drain(input bit sel);
    int n;
    n = 0;
    while (((sel ? qb.size() : qa.size()) != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(sel ? "b_drain_pending" : "a_drain_pending", 64'(sel ? qb.size() : qa.size()), 64'd0);
    if (sel) qb.delete(); else qa.delete();
    @(negedge clk);
  endtask

  // Monitors
  always @(negedge clk) begin
    exp_t e;
    if (a_resp_valid) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_resp: resp_valid=1 with no request pending");
      end else begin
        e = qa.pop_front();
        check("a_rdata", 64'(a_rdata), 64'(e.rdata));
        check("a_err", 64'(a_err), 64'(e.err));
        check("a_latency_cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      check("a_idle_rdata_err", {31'h0, a_err, a_rdata}, 64'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_resp_valid) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_resp: resp_valid=1 with no request pending");
      end else begin
        e = qb.pop_front();
        check("b_rdata", 64'(b_rdata), 64'(e.rdata));
        check("b_err", 64'(b_err), 64'(e.err));
        check("b_latency_cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      check("b_idle_rdata_err", {31'h0, b_err, b_rdata}, 64'd0);
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    #2;
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_a_busy", 64'(a_busy), 64'd0);
    check("rst_a_resp_valid", 64'(a_resp_valid), 64'd0);
    check("rst_b_ready", 64'(b_ready), 64'd0);
    check("rst_b_busy", 64'(b_busy), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_a_ready", 64'(a_ready), 64'd1);
    check("post_rst_b_ready", 64'(b_ready), 64'd1);

    // Full-word store / load
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
    // Byte-masked store over 0xDEADBEEF
    issue(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEAA, 1'b0);
    // Error cases: misaligned, out of range, erroring stores must not write
    issue(1'b0, 1'b0, 32'h12, 32'h0, 4'b0000, 32'h0, 1'b1);
    issue(1'b0, 1'b0, 32'h1000, 32'h0, 4'b0000, 32'h0, 1'b1);
    issue(1'b0, 1'b1, 32'h12, 32'h11111111, 4'b1111, 32'h0, 1'b1);
    issue(1'b0, 1'b1, 32'h1010, 32'h22222222, 4'b1111, 32'h0, 1'b1);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0);
    // Last valid word
    issue(1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 32'hFFC, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);
    // be=0000 no-op, then middle-byte store: DEADBEAA -> DE6677AA
    issue(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0);
    issue(1'b0, 1'b1, 32'h10, 32'h55667788, 4'b0110, 32'h0, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE6677AA, 1'b0);

    // req_valid held high: ready 1 cycle in 4, busy on the other 3
    wait_drain(1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      exp_t e;
      check("stream_ready", 64'(a_ready), 64'((i % 4) == 0));
      check("stream_busy", 64'(a_busy), 64'((i % 4) != 0));
      if (a_ready) begin
        e.rdata = 32'hDE6677AA;
        e.err   = 1'b0;
        e.due   = cyc + 3;
        qa.push_back(e);
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_drain(1'b0);

    // Reset during WAIT aborts a pending store
    issue(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0);
    wait_drain(1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'b1111);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("abort_busy_before", 64'(a_busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(a_busy), 64'd0);
    check("abort_ready", 64'(a_ready), 64'd0);
    check("abort_resp", {30'h0, a_resp_valid, a_err, a_rdata}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready_after", 64'(a_ready), 64'd1);
    issue(1'b0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0);
    wait_drain(1'b0);

    // LATENCY=0 instance
    issue(1'b1, 1'b1, 32'h40, 32'h11223344, 4'b1111, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, 32'h11223344, 1'b0);
    issue(1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, 32'h11223344, 1'b0);
    issue(1'b1, 1'b0, 32'h41, 32'h0, 4'b0000, 32'h0, 1'b1);
    wait_drain(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
